// File: rtl/vga_ctrl.sv
// vga_ctrl: 640x480@60 VGA timing generator with one-cycle pixel lookahead.
// Optional VGA_BORDER_EN: paints a white 1-pixel frame on the visible edge.
module vga_ctrl #(
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int H_VALID = 640,
  parameter int H_FRONT = 16,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33,
  parameter int V_VALID = 480,
  parameter int V_FRONT = 10
) (
  input  logic        vga_clk,
  input  logic        rst,
  input  logic [11:0] pic_data,
  output logic [9:0]  pic_x,
  output logic [9:0]  pic_y,
  output logic        pic_req,
  output logic        hsync,
  output logic        vsync,
  output logic        rgb_valid,
  output logic [11:0] vga_rgb
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;
  localparam int H_START = H_SYNC + H_BACK;
  localparam int V_START = V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SY   = 10'(H_SYNC);
  localparam logic [9:0] V_SY   = 10'(V_SYNC);
  localparam logic [9:0] H_ST   = 10'(H_START);
  localparam logic [9:0] H_END  = 10'(H_START + H_VALID);
  localparam logic [9:0] H_RST  = 10'(H_START - 1);
  localparam logic [9:0] H_REND = 10'(H_START + H_VALID - 1);
  localparam logic [9:0] V_ST   = 10'(V_START);
  localparam logic [9:0] V_END  = 10'(V_START + V_VALID);

  logic [9:0] cnt_h_q, cnt_h_d;
  logic [9:0] cnt_v_q, cnt_v_d;
  logic       v_act;
  logic       h_vis;
  logic       h_req;

  // Next-state for the raster counters; vertical steps on the last column.
  always_comb begin
    cnt_h_d = cnt_h_q + 10'd1;
    cnt_v_d = cnt_v_q;
    if (cnt_h_q == H_LAST) begin
      cnt_h_d = '0;
      if (cnt_v_q == V_LAST) begin
        cnt_v_d = '0;
      end else begin
        cnt_v_d = cnt_v_q + 10'd1;
      end
    end
  end

  // Counter registers; reset parks the raster at the start of both syncs.
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      cnt_h_q <= '0;
      cnt_v_q <= '0;
    end else begin
      cnt_h_q <= cnt_h_d;
      cnt_v_q <= cnt_v_d;
    end
  end

  // Window decodes; the request window leads the visible one by a clock.
  always_comb begin
    v_act = 1'b0;
    h_vis = 1'b0;
    h_req = 1'b0;
    if (cnt_v_q >= V_ST && cnt_v_q < V_END) begin
      v_act = 1'b1;
    end
    if (cnt_h_q >= H_ST && cnt_h_q < H_END) begin
      h_vis = 1'b1;
    end
    if (cnt_h_q >= H_RST && cnt_h_q < H_REND) begin
      h_req = 1'b1;
    end
  end

  // Sync pulses and pixel request coordinates.
  always_comb begin
    hsync     = (cnt_h_q >= H_SY);
    vsync     = (cnt_v_q >= V_SY);
    rgb_valid = v_act & h_vis;
    pic_req   = v_act & h_req;
    pic_x     = '0;
    pic_y     = '0;
    if (pic_req) begin
      pic_x = cnt_h_q - H_RST;
      pic_y = cnt_v_q - V_ST;
    end
  end

`ifdef VGA_BORDER_EN
  logic on_edge;

  // Outermost visible ring is forced white; interior follows pic_data.
  always_comb begin
    on_edge = (cnt_h_q == H_ST) || (cnt_h_q == H_END - 10'd1) ||
              (cnt_v_q == V_ST) || (cnt_v_q == V_END - 10'd1);
    vga_rgb = 12'h000;
    if (rgb_valid) begin
      vga_rgb = on_edge ? 12'hFFF : pic_data;
    end
  end
`else
  // Blank the pins outside the visible window.
  always_comb begin
    vga_rgb = 12'h000;
    if (rgb_valid) begin
      vga_rgb = pic_data;
    end
  end
`endif

endmodule

// File: doc/vga_ctrl.md
Name: vga_ctrl

Overview:
- 640x480@60 Hz VGA timing generator, directly upstream of the picture generator.
- Runs H/V counters on vga_clk and produces hsync/vsync.
- Issues pixel coordinates (pic_x, pic_y) one cycle ahead, because the picture generator has a 1-cycle registered latency.
- Gates the returned 12-bit pic_data onto vga_rgb only inside the visible window.

Parameters:
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch
- H_VALID, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch
- V_VALID, 480, visible lines
- V_FRONT, 10, vertical front porch
- Derived localparams: H_TOTAL = sum of the four H values (800); V_TOTAL = sum of the four V values (525); H_START = H_SYNC+H_BACK (144); V_START = V_SYNC+V_BACK (35).

Ports:
- vga_clk  in  1  pixel clock (~25 MHz)
- rst  in  1  synchronous reset, active-high
- pic_data  in  12  RGB444 from picture stage, valid 1 cycle after matching pic_x/pic_y
- pic_x  out  10  requested pixel column 0..639, 0 when not requesting
- pic_y  out  10  requested pixel row 0..479, 0 when not requesting
- pic_req  out  1  high when pic_x/pic_y carry a real request
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- rgb_valid  out  1  high while the current pixel is visible
- vga_rgb  out  12  pixel to DAC/pins
- Clock and reset: one clock (vga_clk). Reset is synchronous and active-high (rst); the polarity and synchronicity are fixed.

Behaviour:
- cnt_h (10 bit) counts 0..H_TOTAL-1 every clock and wraps to 0.
- cnt_v (10 bit) increments only when cnt_h == H_TOTAL-1, counts 0..V_TOTAL-1 and wraps to 0.
- Simultaneous wrap: at cnt_h = 799 and cnt_v = 524, both counters go to 0 on the next edge.
- Reset: on a rst edge, cnt_h = cnt_v = 0. Reset mid-frame restarts at the start of hsync/vsync with no partial-state carry-over.
- Outputs are combinational decodes of the counters (no extra latency) except where noted:
  - hsync = 0 when cnt_h < H_SYNC, else 1.
  - vsync = 0 when cnt_v < V_SYNC, else 1.
  - After reset both are 0, since the counters sit in the sync region.
- v_act = (V_START <= cnt_v < V_START+V_VALID).
- rgb_valid = v_act && (H_START <= cnt_h < H_START+H_VALID).
- pic_req = v_act && (H_START-1 <= cnt_h < H_START+H_VALID-1), i.e. the visible window advanced by exactly one clock.
- pic_x = pic_req ? cnt_h-(H_START-1) : 0. pic_y = pic_req ? cnt_v-V_START : 0.
- No row lookahead: pic_y is constant across a line.
- vga_rgb = rgb_valid ? pic_data : 12'h000. The pixel shown at cnt_h = H_START+k is the pic_data returned for pic_x = k.
- Reset output values (cnt = 0):
  - pic_req = 0, pic_x = 0, pic_y = 0
  - rgb_valid = 0, vga_rgb = 0
  - hsync = 0, vsync = 0
- Arithmetic is unsigned 10-bit. The subtractions are performed only inside the request window, so they never underflow.
- Per frame: exactly H_VALID*V_VALID = 307200 rgb_valid cycles and H_TOTAL*V_TOTAL = 420000 clocks.

Optional Feature:
- Macro: VGA_BORDER_EN.
- When defined: vga_rgb is forced to 12'hFFF whenever rgb_valid is high and the displayed pixel is on the 1-pixel frame edge. Edge means (cnt_h-H_START) in {0, H_VALID-1} or (cnt_v-V_START) in {0, V_VALID-1}. Elsewhere behaviour is unchanged; timing and pic_* outputs are identical.
- When undefined: no override logic is built, and vga_rgb follows the base rule above.

Test Plan:
- Reset check: assert rst for 3 clocks mid-line, release. Required: hsync=0, vsync=0, pic_req=0, vga_rgb=0 on the first post-reset cycle; cnt_h reaches 96 (hsync rises) exactly 96 clocks after release.
- Horizontal timing: hsync period is 800 clocks, low for 96 clocks. Over a visible line, rgb_valid is high for exactly 640 consecutive clocks starting 144 clocks after the hsync fall.
- Vertical timing: vsync period is 420000 clocks, low for 1600 clocks. Over one frame, exactly 307200 rgb_valid cycles.
- Lookahead: on line cnt_v=35, pic_req rises at cnt_h=143 with pic_x=0, pic_y=0, and pic_x=639 at cnt_h=782. On line cnt_v=514, pic_y=479. On line cnt_v=515, pic_req=0.
- Data path: drive pic_data from a 1-cycle-registered model returning {2'b0,pic_x} masked to 12 bits. vga_rgb must equal the displayed column index for all 640 pixels, and 12'h000 whenever rgb_valid=0, including with pic_data held at 12'hF00.
- VGA_BORDER_EN with pic_data=12'h00F: vga_rgb=12'hFFF at displayed (0,y), (639,y), (x,0), (x,479), and 12'h00F at (1,1) and (320,240). Without the macro, all visible pixels are 12'h00F.
